// File: rtl/fft_ser_pkg.sv
// -----------------------------------------------------------------------------
// fft_ser_pkg
// Shared constants for the 8-point FFT output serializer.
//   N_PTS      : number of FFT bins in one frame
//   IDX_W      : width of a bin index
//   IN_W_DEF   : default FFT output lane width (shared with the FFT core top)
//   OUT_W_DEF  : default streamed component width
//   SHIFT_DEF  : default scale-down shift
// -----------------------------------------------------------------------------
package fft_ser_pkg;

  localparam int N_PTS     = 8;
  localparam int IDX_W     = 3;
  localparam int IN_W_DEF  = 36;
  localparam int OUT_W_DEF = 18;
  localparam int SHIFT_DEF = 10;

  typedef logic [IDX_W-1:0] idx_t;

endpackage : fft_ser_pkg

// File: rtl/fft_ser_scale.sv
// -----------------------------------------------------------------------------
// fft_ser_scale
// Combinational scale-down of one signed component: optional round-half-up,
// arithmetic right shift by SHIFT, then saturation to OUT_W signed bits.
// Build option: define FFT_SER_ROUND_EN to add 2^(SHIFT-1) before the shift;
// otherwise the shift is a plain floor truncation. Saturation is always on.
// Ports:
//   i_din  : IN_W-bit signed input component
//   o_dout : OUT_W-bit signed scaled (and possibly clipped) result
//   o_clip : high when the result was saturated
// -----------------------------------------------------------------------------
module fft_ser_scale
  import fft_ser_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout,
  output logic                    o_clip
);

  // One guard bit so the rounding add on a maximal positive input cannot wrap.
  localparam int EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
  // Two's complement: ~(2^n - 1) == -2^n.
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_rnd;
  logic signed [EXT_W-1:0] w_shr;

  assign w_ext = $signed({i_din[IN_W-1], i_din});

`ifdef FFT_SER_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_V = EXT_W'(1) << (SHIFT - 1);
  assign w_rnd = w_ext + RND_V;
`else
  assign w_rnd = w_ext;
`endif

  assign w_shr = w_rnd >>> SHIFT;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    o_dout = w_shr[OUT_W-1:0];
    o_clip = 1'b0;
    if (w_shr > MAX_V) begin
      o_dout = MAX_V[OUT_W-1:0];
      o_clip = 1'b1;
    end else if (w_shr < MIN_V) begin
      o_dout = MIN_V[OUT_W-1:0];
      o_clip = 1'b1;
    end
  end

endmodule : fft_ser_scale

// File: rtl/fft_out_serializer.sv
// -----------------------------------------------------------------------------
// fft_out_serializer
// Captures one parallel frame of 8 complex FFT results into a ping-pong
// buffer and streams it out one scaled, saturated complex sample per cycle.
// Build option: FFT_SER_ROUND_EN selects round-half-up scaling (see
// fft_ser_scale); undefined gives floor truncation.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : frame handshake; capture on in_valid && in_ready
//   in_re, in_im        : 8 packed IN_W-bit lanes, lane k = bin k
//   out_valid/out_ready : per-beat handshake
//   out_re, out_im      : scaled components of bin out_idx
//   out_idx, out_last   : bin index, high on bin 7
//   out_sat             : re or im of this beat was clipped
// -----------------------------------------------------------------------------
module fft_out_serializer
  import fft_ser_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_PTS*IN_W-1:0]    in_re,
  input  logic [N_PTS*IN_W-1:0]    in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     out_sat
);

  localparam idx_t LAST_IDX = idx_t'(N_PTS - 1);

  logic        r_wr_bank;
  logic        r_rd_bank;
  logic [1:0]  r_full;
  idx_t        r_cnt;
  logic [IN_W-1:0] r_re [2][N_PTS];
  logic [IN_W-1:0] r_im [2][N_PTS];

  logic w_capture;
  logic w_beat;
  logic w_frame_done;
  logic signed [IN_W-1:0] w_rd_re;
  logic signed [IN_W-1:0] w_rd_im;
  logic w_clip_re;
  logic w_clip_im;

  // Both handshakes depend only on registered state, so a bank freed on its
  // last beat becomes writable one cycle later.
  assign in_ready     = ~r_full[r_wr_bank];
  assign out_valid    = r_full[r_rd_bank];
  assign w_capture    = in_valid && in_ready;
  assign w_beat       = out_valid && out_ready;
  assign w_frame_done = w_beat && (r_cnt == LAST_IDX);

  // Capture needs full[wr]=0 and frame_done needs full[rd]=1, so when both
  // fire in one cycle they always touch different bits of r_full.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
      r_cnt     <= '0;
    end else begin
      if (w_capture) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_frame_done) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
        r_cnt             <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + idx_t'(1);
      end
    end
  end

  // NOTE: the bank storage is reset on purpose: the outputs are combinational
  // from storage and must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N_PTS; k++) begin
          r_re[b][k] <= '0;
          r_im[b][k] <= '0;
        end
      end
    end else if (w_capture) begin
      for (int k = 0; k < N_PTS; k++) begin
        r_re[r_wr_bank][k] <= in_re[k*IN_W +: IN_W];
        r_im[r_wr_bank][k] <= in_im[k*IN_W +: IN_W];
      end
    end
  end

  assign w_rd_re = r_re[r_rd_bank][r_cnt];
  assign w_rd_im = r_im[r_rd_bank][r_cnt];

  fft_ser_scale #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_scale_re (
    .i_din  (w_rd_re),
    .o_dout (out_re),
    .o_clip (w_clip_re)
  );

  fft_ser_scale #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_scale_im (
    .i_din  (w_rd_im),
    .o_dout (out_im),
    .o_clip (w_clip_im)
  );

  assign out_idx  = r_cnt;
  assign out_last = (r_cnt == LAST_IDX);
  assign out_sat  = w_clip_re | w_clip_im;

endmodule : fft_out_serializer
